multicycle_ctrl: RTL and testbench

//  Multicycle control unit for the ARM-subset datapath: FSM-sequenced successor of the combinational decoder.

---
 rtl/multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle FSM control unit for the ARM-subset datapath
// Sequences fetch/decode/execute/memory/writeback and owns the NZCV flags register.
module multicycle_ctrl #(
  parameter int INSTR_W     = 32,
  parameter int ALUCTRL_W   = 3,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTR_W-1:0]   instr,
  input  logic [3:0]           alu_flags,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 adr_src,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           reg_src,
  output logic [1:0]           imm_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [3:0]           flags,
  output logic                 instr_done,
  output logic                 illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB,
    S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH
  } state_t;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(6);
  localparam bit WAIT_EN = (MEM_WAIT_EN != 0);

  state_t state, state_nx;
  logic [3:0] flags_q, flags_nx;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cond, cmd;
  logic       mr, cond_ok, rd_pc, unused_bits;

  assign cond  = instr[31:28];
  assign op    = instr[27:26];
  assign funct = instr[25:20];
  assign rd    = instr[15:12];
  assign cmd   = funct[4:1];
  assign rd_pc = (rd == 4'hF);
  assign mr    = !WAIT_EN || mem_ready;
  assign unused_bits = ^instr;

  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = z_f;
      4'h1: cond_ok = !z_f;
      4'h2: cond_ok = c_f;
      4'h3: cond_ok = !c_f;
      4'h4: cond_ok = n_f;
      4'h5: cond_ok = !n_f;
      4'h6: cond_ok = v_f;
      4'h7: cond_ok = !v_f;
      4'h8: cond_ok = c_f && !z_f;
      4'h9: cond_ok = !c_f || z_f;
      4'hA: cond_ok = (n_f == v_f);
      4'hB: cond_ok = (n_f != v_f);
      4'hC: cond_ok = !z_f && (n_f == v_f);
      4'hD: cond_ok = z_f || (n_f != v_f);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  logic [ALUCTRL_W-1:0] dp_alu;
  logic                 dp_logic, dp_cmp;
  always_comb begin
    dp_alu = ALU_ADD;
    case (cmd)
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b1010: dp_alu = ALU_SUB;
      default: dp_alu = ALU_ADD;
    endcase
  end
  assign dp_logic = (cmd == 4'b0000) || (cmd == 4'b1100);
  assign dp_cmp   = (cmd == 4'b1010);

  logic                 mem_read_c, mem_write_c, ir_write_c, adr_src_c;
  logic                 pc_write_c, reg_write_c, done_c, illegal_c;
  logic [1:0]           reg_src_c, imm_src_c, src_a_c, src_b_c, res_c;
  logic [ALUCTRL_W-1:0] alu_c;

  always_comb begin
    state_nx    = state;
    flags_nx    = flags_q;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    adr_src_c   = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    illegal_c   = 1'b0;
    reg_src_c   = 2'b00;
    imm_src_c   = 2'b00;
    src_a_c     = 2'b00;
    src_b_c     = 2'b00;
    res_c       = 2'b00;
    alu_c       = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_read_c = 1'b1;
        src_a_c    = 2'b01;
        src_b_c    = 2'b10;
        res_c      = 2'b10;
        if (mr) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_nx   = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a_c      = 2'b01;
        src_b_c      = 2'b10;
        imm_src_c    = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
        reg_src_c[0] = (op == 2'b10);
        reg_src_c[1] = (op == 2'b01) && !funct[0];
        if (!cond_ok) begin
          done_c   = 1'b1;
          state_nx = S_FETCH;
        end else begin
          case (op)
            2'b00:   state_nx = funct[5] ? S_EXECI : S_EXECR;
            2'b01:   state_nx = S_MEMADR;
            2'b10:   state_nx = S_BRANCH;
            default: begin
              illegal_c = 1'b1;
              done_c    = 1'b1;
              state_nx  = S_FETCH;
            end
          endcase
        end
      end
      S_EXECR, S_EXECI: begin
        src_b_c = (state == S_EXECI) ? 2'b01 : 2'b00;
        alu_c   = dp_alu;
        // Logical ops leave C/V alone so a prior shift/arith carry survives
        if (funct[0])
          flags_nx = dp_logic ? {alu_flags[3:2], flags_q[1:0]} : alu_flags;
        if (dp_cmp) begin
          done_c   = 1'b1;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_ALUWB;
        end
      end
      S_ALUWB, S_MEMWB: begin
        res_c       = (state == S_MEMWB) ? 2'b01 : 2'b00;
        pc_write_c  = rd_pc;
        reg_write_c = !rd_pc;
        done_c      = 1'b1;
        state_nx    = S_FETCH;
      end
      S_MEMADR: begin
        src_b_c   = 2'b01;
        imm_src_c = 2'b01;
        alu_c     = funct[3] ? ALU_ADD : ALU_SUB;
        state_nx  = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        adr_src_c  = 1'b1;
        if (mr) state_nx = S_MEMWB;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        reg_src_c   = 2'b10;
        if (mr) begin
          done_c   = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_BRANCH: begin
        src_a_c    = 2'b10;
        src_b_c    = 2'b01;
        imm_src_c  = 2'b10;
        res_c      = 2'b10;
        pc_write_c = 1'b1;
        done_c     = 1'b1;
        state_nx   = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state   <= state_nx;
      flags_q <= flags_nx;
    end
  end

  // Gate with rst_n so the FETCH decode does not leak out while held in reset
  assign mem_read    = rst_n && mem_read_c;
  assign mem_write   = rst_n && mem_write_c;
  assign ir_write    = rst_n && ir_write_c;
  assign adr_src     = rst_n && adr_src_c;
  assign pc_write    = rst_n && pc_write_c;
  assign reg_write   = rst_n && reg_write_c;
  assign instr_done  = rst_n && done_c;
  assign illegal     = rst_n && illegal_c;
  assign reg_src     = rst_n ? reg_src_c : 2'b00;
  assign imm_src     = rst_n ? imm_src_c : 2'b00;
  assign alu_src_a   = rst_n ? src_a_c : 2'b00;
  assign alu_src_b   = rst_n ? src_b_c : 2'b00;
  assign result_src  = rst_n ? res_c : 2'b00;
  assign alu_control = rst_n ? alu_c : '0;
  assign flags       = flags_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [3:0]  alu_flags = 4'h0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  logic       mrd1, mwr1, irw1, adr1, pcw1, rgw1, dn1, ill1;
  logic [1:0] rs1, is1, sa1, sb1, res1;
  logic [2:0] ac1;
  logic [3:0] fl1;
  logic       mrd0, mwr0, irw0, adr0, pcw0, rgw0, dn0, ill0;
  logic [1:0] rs0, is0, sa0, sb0, res0;
  logic [2:0] ac0;
  logic [3:0] fl0;

  multicycle_ctrl #(.INSTR_W(32), .ALUCTRL_W(3), .MEM_WAIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_flags(alu_flags), .mem_ready(mem_ready),
    .mem_read(mrd1), .mem_write(mwr1), .ir_write(irw1), .adr_src(adr1), .pc_write(pcw1),
    .reg_write(rgw1), .reg_src(rs1), .imm_src(is1), .alu_src_a(sa1), .alu_src_b(sb1),
    .result_src(res1), .alu_control(ac1), .flags(fl1), .instr_done(dn1), .illegal(ill1)
  );

  multicycle_ctrl #(.INSTR_W(32), .ALUCTRL_W(3), .MEM_WAIT_EN(0)) dut_nowait (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_flags(alu_flags), .mem_ready(1'b0),
    .mem_read(mrd0), .mem_write(mwr0), .ir_write(irw0), .adr_src(adr0), .pc_write(pcw0),
    .reg_write(rgw0), .reg_src(rs0), .imm_src(is0), .alu_src_a(sa0), .alu_src_b(sb0),
    .result_src(res0), .alu_control(ac0), .flags(fl0), .instr_done(dn0), .illegal(ill0)
  );

  // {mem_read, mem_write, ir_write, adr_src, pc_write, reg_write, instr_done, illegal}
  logic [7:0]  ctl1, ctl0;
  logic [24:0] all1;
  assign ctl1 = {mrd1, mwr1, irw1, adr1, pcw1, rgw1, dn1, ill1};
  assign ctl0 = {mrd0, mwr0, irw0, adr0, pcw0, rgw0, dn0, ill0};
  assign all1 = {ctl1, rs1, is1, sa1, sb1, res1, ac1, fl1};

  typedef struct {
    string      tag;
    logic       mr;
    logic [7:0] ctl;
    logic       ac_en;
    logic [2:0] ac;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   use_nowait = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic mr, input logic [7:0] ctl,
                      input logic ac_en = 1'b0, input logic [2:0] ac = 3'd0);
    exp_t e;
    e.tag = tag; e.mr = mr; e.ctl = ctl; e.ac_en = ac_en; e.ac = ac;
    sbq.push_back(e);
  endtask

  // One queue entry per clock: drive mem_ready, sample mid-cycle, advance
  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      mem_ready = e.mr;
      #2;
      check(e.tag, 32'(use_nowait ? ctl0 : ctl1), 32'(e.ctl));
      if (e.ac_en)
        check({e.tag, "_alu"}, 32'(use_nowait ? ac0 : ac1), 32'(e.ac));
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    #2 check("rst_all", 32'(all1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    instr = 32'hE0911002; alu_flags = 4'b0110;
    push("adds_f", 1, 8'hA8); push("adds_d", 1, 8'h00);
    push("adds_ex", 1, 8'h00, 1, 3'd0); push("adds_wb", 1, 8'h06);
    drain();
    check("adds_flags", 32'(fl1), 32'h6);

    instr = 32'hE5912004; alu_flags = 4'b0000;
    push("ldr_f", 1, 8'hA8); push("ldr_d", 1, 8'h00); push("ldr_ma", 1, 8'h00, 1, 3'd0);
    push("ldr_rd0", 0, 8'h90); push("ldr_rd1", 0, 8'h90); push("ldr_rd2", 0, 8'h90);
    push("ldr_rd3", 1, 8'h90); push("ldr_wb", 1, 8'h06);
    drain();

    push("abort_f", 1, 8'hA8); push("abort_d", 1, 8'h00); push("abort_ma", 1, 8'h00);
    push("abort_rd", 0, 8'h90);
    drain();
    rst_n = 1'b0;
    #2 check("abort_all", 32'(all1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #2 check("rel_fetch", 32'(ctl1), 32'h80);
    check("rel_mux", 32'({sa1, sb1, res1, ac1}), 32'({2'b01, 2'b10, 2'b10, 3'd0}));
    check("rel_flags", 32'(fl1), 32'h0);
    @(negedge clk);

    instr = 32'hE1510002; alu_flags = 4'b0110;
    push("cmp_f", 1, 8'hA8); push("cmp_d", 1, 8'h00); push("cmp_ex", 1, 8'h02, 1, 3'd1);
    drain();
    check("cmp_flags", 32'(fl1), 32'h6);

    instr = 32'h0A000002; alu_flags = 4'b0000;
    push("beq_f", 1, 8'hA8); push("beq_d", 1, 8'h00); push("beq_br", 1, 8'h0A);
    drain();

    instr = 32'hE0111002; alu_flags = 4'b1001;
    push("ands_f", 1, 8'hA8); push("ands_d", 1, 8'h00);
    push("ands_ex", 1, 8'h00, 1, 3'd2); push("ands_wb", 1, 8'h06);
    drain();
    check("ands_flags", 32'(fl1), 32'hA);

    instr = 32'h0A000002;
    push("beqn_f", 1, 8'hA8); push("beqn_d", 1, 8'h02);
    drain();

    instr = 32'hE1A0F001; alu_flags = 4'b1111;
    push("movpc_f", 1, 8'hA8); push("movpc_d", 1, 8'h00);
    push("movpc_ex", 1, 8'h00, 1, 3'd0); push("movpc_wb", 1, 8'h0A);
    drain();
    check("movpc_flags", 32'(fl1), 32'hA);

    instr = 32'hEC000000;
    push("ill_f", 1, 8'hA8); push("ill_d", 1, 8'h03);
    drain();

    instr = 32'hF0911002;
    push("nv_f", 1, 8'hA8); push("nv_d", 1, 8'h02);
    drain();

    instr = 32'hE5012004;
    push("str_f", 1, 8'hA8); push("str_d", 1, 8'h00); push("str_ma", 1, 8'h00, 1, 3'd1);
    push("str_wr0", 0, 8'h50); push("str_wr1", 1, 8'h52); push("str_next", 1, 8'hA8);
    drain();

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    use_nowait = 1'b1;
    push("nw_f", 0, 8'hA8); push("nw_d", 0, 8'h00); push("nw_ma", 0, 8'h00, 1, 3'd1);
    push("nw_wr", 0, 8'h52); push("nw_next", 0, 8'hA8);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
